// File: rtl/shot_ctrl_multi_if.sv
// Trigger/shot bundle between a controller and the multi-channel shot block.
// The block side uses the slave modport.
interface shot_ctrl_multi_if #(
  parameter int CH    = 4,
  parameter int CNT_W = 8
);
  logic [CH-1:0]    Start;
  logic             mode;
  logic             clr;
  logic [CH-1:0]    Shot;
  logic [CH-1:0]    busy;
  logic [CNT_W-1:0] fire_cnt;

  modport master (output Start, mode, clr, input  Shot, busy, fire_cnt);
  modport slave  (input  Start, mode, clr, output Shot, busy, fire_cnt);
endinterface

// File: rtl/shot_ctrl_multi.sv
// Multi-channel one-shot controller: one arm/fire FSM per channel plus a
// shared saturating counter of FIRE entries.

module shot_ctrl_lane #(
  parameter int PULSE_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic mode,
  output logic shot,
  output logic busy,
  output logic fire
);
  localparam int CW = $clog2(PULSE_W + 1);

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    IDLE  = 3'd1,
    ARMED = 3'd2,
    FIRE  = 3'd3,
    WAIT  = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // Only consumed by the shared counter; Shot itself stays a pure state decode.
  assign fire = (state == ARMED) && start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= INIT;
      cnt   <= '0;
      shot  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          state <= IDLE;
          shot  <= 1'b0;
          busy  <= 1'b0;
        end
        // A level already high out of reset must drop before it can arm.
        IDLE: if (!start) state <= ARMED;
        ARMED: if (start) begin
          state <= FIRE;
          cnt   <= CW'(PULSE_W - 1);
          shot  <= 1'b1;
          busy  <= 1'b1;
        end
        FIRE: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (!(mode && start)) begin
            shot <= 1'b0;
            if (start) begin
              state <= WAIT;
            end else begin
              state <= ARMED;
              busy  <= 1'b0;
            end
          end
        end
        WAIT: if (!start) begin
          state <= ARMED;
          busy  <= 1'b0;
        end
        default: begin
          state <= INIT;
          cnt   <= '0;
          shot  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

module shot_ctrl_multi #(
  parameter int CH      = 4,
  parameter int PULSE_W = 4,
  parameter int CNT_W   = 8
) (
  input logic              clk,
  input logic              reset,
  shot_ctrl_multi_if.slave bus
);
  // Headroom for adding up to 16 fires in one cycle before saturation.
  localparam int SW = CNT_W + 5;
  localparam logic [SW-1:0] CNT_MAX = SW'((1 << CNT_W) - 1);

  logic [CH-1:0] shot_v, busy_v, fire_v;
  logic [SW-1:0] add, sum;
  logic [CNT_W-1:0] cnt_q;

  for (genvar i = 0; i < CH; i++) begin : g_lane
    shot_ctrl_lane #(.PULSE_W(PULSE_W)) u_lane (
      .clk   (clk),
      .reset (reset),
      .start (bus.Start[i]),
      .mode  (bus.mode),
      .shot  (shot_v[i]),
      .busy  (busy_v[i]),
      .fire  (fire_v[i])
    );
  end

  always_comb begin
    add = '0;
    for (int i = 0; i < CH; i++) add = add + SW'(fire_v[i]);
  end

  assign sum = SW'(cnt_q) + add;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             cnt_q <= '0;
    else if (bus.clr)       cnt_q <= '0;
    else if (sum > CNT_MAX) cnt_q <= '1;
    else                    cnt_q <= sum[CNT_W-1:0];
  end

  assign bus.Shot     = shot_v;
  assign bus.busy     = busy_v;
  assign bus.fire_cnt = cnt_q;
endmodule

// File: doc/shot_ctrl_multi.md
SHOT_CTRL_MULTI -- requirements
Module: shot_ctrl_multi

Interface
REQ-001 Parameter: CH, default 4, number of independent channels (1..16).
REQ-002 Parameter: PULSE_W, default 4, shot pulse width in clock cycles (1..255).
REQ-003 Parameter: CNT_W, default 8, width of the shared fire counter (4..16).
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-low reset.
REQ-006 Port: Start  input  CH  per-channel trigger level, synchronous to clk.
REQ-007 Port: mode  input  1  0 = fixed-width pulse, 1 = stretch (shot held while Start high); sampled each cycle.
REQ-008 Port: clr  input  1  synchronous clear of fire_cnt.
REQ-009 Port: Shot  output  CH  per-channel shot pulse.
REQ-010 Port: busy  output  CH  per-channel high while in FIRE or WAIT.
REQ-011 Port: fire_cnt  output  CNT_W  saturating count of FIRE entries, all channels.

Function
REQ-012 Each channel SHALL run an independent FSM with states INIT, IDLE, ARMED, FIRE, WAIT.
REQ-013 INIT SHALL go to IDLE unconditionally on the next clock; Shot=0.
REQ-014 IDLE: Start[i]=0 -> ARMED; Start[i]=1 -> stay (no fire on a level already high at reset release).
REQ-015 ARMED: Start[i]=1 sampled -> FIRE and load pulse counter with PULSE_W-1; else stay.
REQ-016 FIRE: Shot[i]=1; counter decrements each cycle; Start[i] edges during FIRE SHALL be ignored (no retrigger).
REQ-017 FIRE exit when counter=0: mode=0 -> ARMED if Start[i]=0 else WAIT; mode=1 -> stay in FIRE while Start[i]=1, go to ARMED on the first cycle Start[i]=0.
REQ-018 WAIT: Shot[i]=0; Start[i]=0 -> ARMED.
REQ-019 Shot[i] SHALL be a decode of state only: 1 exactly in FIRE, 0 elsewhere; no Start-to-Shot combinational path.
REQ-020 Latency: Start[i] sampled 1 in ARMED at edge k -> Shot[i]=1 from edge k through edge k+PULSE_W (PULSE_W cycles) in mode 0.
REQ-021 Minimum re-fire spacing: PULSE_W+1 cycles (FIRE, then at least one ARMED cycle sampling Start=0 then 1).
REQ-022 Pulse counter width SHALL be ceil(log2(PULSE_W+1)) bits; PULSE_W=1 gives a single-cycle pulse.
REQ-023 fire_cnt SHALL add the number of channels entering FIRE in a cycle (popcount, 0..CH), saturating at 2^CNT_W-1.
REQ-024 clr=1 SHALL force fire_cnt to 0 on that edge, taking priority over simultaneous fires.
REQ-025 Illegal/unencoded state SHALL return to INIT on the next clock.
REQ-026 mode changes mid-FIRE SHALL take effect at the counter=0 decision only.

Reset
REQ-027 reset=0 SHALL immediately (asynchronously) force all channels to INIT, Shot=0, busy=0, pulse counters=0, fire_cnt=0.
REQ-028 Reset asserted mid-FIRE SHALL truncate the pulse; no pulse resumes after release.
REQ-029 After release, first possible Shot is 3 cycles later (INIT, IDLE, ARMED) given Start=0 then 1.

Verification (CH=4, PULSE_W=4, CNT_W=8)
REQ-030 Release reset with Start=0000, raise Start[0] on cycle 5 -> Shot[0] high exactly 4 cycles starting next cycle, fire_cnt=1.
REQ-031 Start=1111 held through reset release -> no Shot until each channel sees 0 then 1.
REQ-032 mode=1, Start[2] high 10 cycles -> Shot[2] high 10 cycles (not 4); mode=0 same stimulus -> 4 cycles then WAIT, busy[2] high until Start[2] falls.
REQ-033 All four Start rise together, clr=1 on that edge -> four shots, fire_cnt=0; repeat with clr=0 -> fire_cnt=4.
REQ-034 Toggle Start[1] every cycle for 40 cycles -> pulses 4 wide, spaced >=5 cycles, no retrigger inside FIRE; fire_cnt driven to 255 by long run stays 255.
REQ-035 Assert reset on 2nd cycle of a pulse -> Shot drops same cycle asynchronously, fire_cnt=0, no resumption after release.
